// File: rtl/iir_stereo_sched.sv
// iir_stereo_sched
//   Shares one first-order IIR datapath (a single multiplier) between the left
//   and right stereo channels. Channels are granted round-robin. Each channel
//   keeps its own x[n-1]/y[n-1] history.
//   y[n] = DEQ(B0*x[n]) + DEQ(B1*x[n-1]) + DEQ(A1*y[n-1])
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   din_l/r, in_empty_l/r    input FIFO data and empty flags
//   in_rd_en_l/r             input FIFO pops (registered, one-cycle pulses)
//   dout_l/r                 result, both driven from the shared accumulator
//   out_full_l/r             output FIFO full flags
//   out_wr_en_l/r            output FIFO pushes (registered, one-cycle pulses)
//   busy                     FSM is not idle
//   grant_r                  channel in process: 0 = L, 1 = R
//
// state  | meaning
// S_IDLE | pick an eligible channel, latch its sample into x0, pop it
// S_M0   | acc = DEQ(B0*x0)
// S_M1   | acc += DEQ(B1*x1[c])
// S_M2   | acc += DEQ(A1*y1[c])
// S_WR   | push acc when output not full, update history, rotate priority

module iir_stereo_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int Q_BITS     = 10,
   parameter int B0         = 178,
   parameter int B1         = 178,
   parameter int A1         = -666
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din_l,
   input  logic                  in_empty_l,
   output logic                  in_rd_en_l,
   input  logic [DATA_WIDTH-1:0] din_r,
   input  logic                  in_empty_r,
   output logic                  in_rd_en_r,
   output logic [DATA_WIDTH-1:0] dout_l,
   input  logic                  out_full_l,
   output logic                  out_wr_en_l,
   output logic [DATA_WIDTH-1:0] dout_r,
   input  logic                  out_full_r,
   output logic                  out_wr_en_r,
   output logic                  busy,
   output logic                  grant_r
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam logic signed [DATA_WIDTH-1:0] B0_C = DATA_WIDTH'(B0);
   localparam logic signed [DATA_WIDTH-1:0] B1_C = DATA_WIDTH'(B1);
   localparam logic signed [DATA_WIDTH-1:0] A1_C = DATA_WIDTH'(A1);
   // Added to negative products before the arithmetic shift so DEQ rounds toward zero.
   localparam logic signed [PW-1:0] RND = (PW'(1) << Q_BITS) - PW'(1);

   typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_WR} state_t;

   state_t                        state;
   logic signed [DATA_WIDTH-1:0]  x0;
   logic signed [DATA_WIDTH-1:0]  acc;
   logic signed [DATA_WIDTH-1:0]  x1 [2];
   logic signed [DATA_WIDTH-1:0]  y1 [2];
   logic                          prio;

   logic                          elig_l;
   logic                          elig_r;
   logic                          full_c;
   logic signed [DATA_WIDTH-1:0]  mul_a;
   logic signed [DATA_WIDTH-1:0]  mul_b;
   logic signed [PW-1:0]          prod;
   logic signed [PW-1:0]          bias;
   logic signed [PW-1:0]          deq_full;
   logic signed [DATA_WIDTH-1:0]  deq_res;

   assign elig_l = !in_empty_l && !out_full_l;
   assign elig_r = !in_empty_r && !out_full_r;
   assign full_c = grant_r ? out_full_r : out_full_l;

   // Operand mux in front of the single shared multiplier.
   always_comb begin
      mul_a = B0_C;
      mul_b = x0;
      case (state)
         S_M1: begin
            mul_a = B1_C;
            mul_b = x1[grant_r];
         end
         S_M2: begin
            mul_a = A1_C;
            mul_b = y1[grant_r];
         end
         default: ;
      endcase
   end

   assign prod     = PW'(mul_a) * PW'(mul_b);
   assign bias     = prod[PW-1] ? RND : '0;
   assign deq_full = (prod + bias) >>> Q_BITS;
   assign deq_res  = deq_full[DATA_WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         x0          <= '0;
         acc         <= '0;
         x1[0]       <= '0;
         x1[1]       <= '0;
         y1[0]       <= '0;
         y1[1]       <= '0;
         prio        <= 1'b0;
         grant_r     <= 1'b0;
         in_rd_en_l  <= 1'b0;
         in_rd_en_r  <= 1'b0;
         out_wr_en_l <= 1'b0;
         out_wr_en_r <= 1'b0;
      end else begin
         in_rd_en_l  <= 1'b0;
         in_rd_en_r  <= 1'b0;
         out_wr_en_l <= 1'b0;
         out_wr_en_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (elig_l && (!elig_r || !prio)) begin
                  in_rd_en_l <= 1'b1;
                  x0         <= din_l;
                  grant_r    <= 1'b0;
                  state      <= S_M0;
               end else if (elig_r) begin
                  in_rd_en_r <= 1'b1;
                  x0         <= din_r;
                  grant_r    <= 1'b1;
                  state      <= S_M0;
               end
            end
            S_M0: begin
               acc   <= deq_res;
               state <= S_M1;
            end
            S_M1: begin
               acc   <= acc + deq_res;
               state <= S_M2;
            end
            S_M2: begin
               acc   <= acc + deq_res;
               state <= S_WR;
            end
            S_WR: begin
               if (!full_c) begin
                  if (grant_r) out_wr_en_r <= 1'b1;
                  else         out_wr_en_l <= 1'b1;
                  x1[grant_r] <= x0;
                  y1[grant_r] <= acc;
                  prio        <= ~grant_r;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (state != S_IDLE);
   assign dout_l = acc;
   assign dout_r = acc;

endmodule
